// File: rtl/pitch_to_cv_pkg.sv
// Shared states, widths and helper functions for the pitch-to-CV tracker.
package pitch_to_cv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam int CV_PER_OCTAVE = 4000;
  localparam int LUT_BITS      = 8;
  localparam int CV_ACC_W      = 20;
  localparam int PERIOD_W      = 16;
  localparam int LOG_W         = 16;
  localparam int LUT_DEPTH     = 1 << LUT_BITS;

  // Fraction-of-octave table entry, evaluated at elaboration only.
  function automatic logic [11:0] log2_frac(input int idx);
    real oct;
    oct = real'(CV_PER_OCTAVE) * $ln(1.0 + real'(idx) / real'(LUT_DEPTH)) / $ln(2.0);
    return 12'($rtoi(oct + 0.5));
  endfunction

  // Clamp the wide signed CV to the 16-bit signed output range.
  function automatic logic signed [15:0] sat16(input logic signed [CV_ACC_W-1:0] v);
    logic signed [15:0] r;
    if (v > 20'sd32767) begin
      r = 16'sh7FFF;
    end else if (v < -20'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pitch_to_cv_period_log2.sv
// period_log2: two-stage log2 of a period in CV counts (4000 per octave).
// Stage 1 finds the leading one and normalises; stage 2 reads the fraction table.
module period_log2
  import pitch_to_cv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [PERIOD_W-1:0] period,
  output logic                out_valid,
  output logic [LOG_W-1:0]    log_val
);

  logic [3:0]          msb_s;
  logic [PERIOD_W-1:0] norm_s;
  logic [3:0]          exp_r;
  logic [LUT_BITS-1:0] frac_r;
  logic                v1_r;
  logic [11:0]         lut_rom_s [LUT_DEPTH];

  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
    assign lut_rom_s[g] = log2_frac(g);
  end

  // Leading-one index, and the period shifted so that one lands on bit 15.
  always_comb begin
    msb_s = 4'd0;
    for (int i = 0; i < PERIOD_W; i++) begin
      msb_s = period[i] ? 4'(i) : msb_s;
    end
    norm_s = period << (4'd15 - msb_s);
  end

  // Stage 1: exponent and the 8 mantissa bits just below the leading one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r   <= 1'b0;
      exp_r  <= 4'd0;
      frac_r <= LUT_BITS'(0);
    end else begin
      v1_r   <= in_valid;
      exp_r  <= msb_s;
      frac_r <= LUT_BITS'(norm_s >> 4'd7);
    end
  end

  // Stage 2: whole octaves plus table fraction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      log_val   <= LOG_W'(0);
    end else begin
      out_valid <= v1_r;
      log_val   <= LOG_W'(exp_r) * LOG_W'(CV_PER_OCTAVE) + LOG_W'(lut_rom_s[frac_r]);
    end
  end

endmodule

// File: rtl/pitch_to_cv.sv
// pitch_to_cv: zero-crossing pitch tracker producing V/Oct CV, gate and square.
// Optional output smoothing is enabled by defining PITCH_TO_CV_SMOOTH_EN.
module pitch_to_cv
  import pitch_to_cv_pkg::*;
#(
  parameter int W             = 16,
  parameter int HYST          = 256,
  parameter int MIN_PERIOD    = 16,
  parameter int MAX_PERIOD    = 4096,
  parameter int CV_OFFSET     = 46078,
  parameter int GATE_HIGH     = 20000,
  parameter     LOG2_LUT_PATH = "util/pitch/log2_lut.hex"
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_strobe,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3,
  input  logic [7:0]          jack
);

  // The fraction table is built from the package function; the path is kept for build compatibility.
  localparam int unused_lut_path_bits = $bits(LOG2_LUT_PATH);

  state_e                     state_r, state_next_s;
  logic                       comp_r, comp_next_s;
  logic                       hi_s, lo_s, rise_s, in_range_s, timeout_s, cap_s;
  logic [PERIOD_W-1:0]        counter_r, counter_next_s, cnt_inc_s, period_s;
  logic                       cap_valid_r;
  logic [PERIOD_W-1:0]        cap_period_r;
  logic                       log_valid_s;
  logic [LOG_W-1:0]           log_val_s;
  logic signed [CV_ACC_W-1:0] cv_raw_s;
  logic signed [W-1:0]        cv_new_s;
  logic                       update_s;
  logic                       unused_s;

  assign unused_s = ^{sample_in1, sample_in2, sample_in3, jack};

  assign hi_s = int'(sample_in0) > HYST;
  assign lo_s = int'(sample_in0) < -HYST;

  // Hysteresis comparator, rising-edge detect and saturating strobe count.
  always_comb begin
    comp_next_s = comp_r;
    if (sample_strobe && hi_s) begin
      comp_next_s = 1'b1;
    end else if (sample_strobe && lo_s) begin
      comp_next_s = 1'b0;
    end else begin
      comp_next_s = comp_r;
    end
    rise_s     = comp_next_s & ~comp_r;
    cnt_inc_s  = (int'(counter_r) > MAX_PERIOD) ? counter_r : counter_r + PERIOD_W'(1);
    period_s   = counter_r + PERIOD_W'(1);
    in_range_s = (int'(period_s) >= MIN_PERIOD) && (int'(period_s) <= MAX_PERIOD);
    // Give up on the strobe after which no period could still be accepted.
    timeout_s  = sample_strobe & ~rise_s & (int'(cnt_inc_s) >= MAX_PERIOD);
  end

  // Next state, counter and capture decision; an edge beats the timeout.
  always_comb begin
    state_next_s   = state_r;
    counter_next_s = counter_r;
    cap_s          = 1'b0;
    if (sample_strobe) begin
      counter_next_s = cnt_inc_s;
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            counter_next_s = PERIOD_W'(0);
            state_next_s   = MEASURE;
          end else begin
            state_next_s = IDLE;
          end
        end
        MEASURE, LOCKED: begin
          if (rise_s) begin
            counter_next_s = PERIOD_W'(0);
            cap_s          = in_range_s;
            state_next_s   = in_range_s ? LOCKED : MEASURE;
          end else if (timeout_s) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = state_r;
          end
        end
        default: state_next_s = IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Tracker state, capture register, gate and square outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      comp_r       <= 1'b0;
      counter_r    <= PERIOD_W'(0);
      cap_valid_r  <= 1'b0;
      cap_period_r <= PERIOD_W'(0);
      sample_out1  <= W'(0);
      sample_out2  <= W'(-GATE_HIGH);
    end else begin
      state_r      <= state_next_s;
      comp_r       <= comp_next_s;
      counter_r    <= counter_next_s;
      cap_valid_r  <= cap_s;
      cap_period_r <= cap_s ? period_s : cap_period_r;
      sample_out1  <= (state_next_s == LOCKED) ? W'(GATE_HIGH) : W'(0);
      sample_out2  <= comp_next_s ? W'(GATE_HIGH) : W'(-GATE_HIGH);
    end
  end

  period_log2 u_period_log2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (cap_valid_r),
    .period    (cap_period_r),
    .out_valid (log_valid_s),
    .log_val   (log_val_s)
  );

  assign cv_raw_s = $signed(CV_ACC_W'(CV_OFFSET)) - $signed(CV_ACC_W'(log_val_s));
  assign cv_new_s = W'(sat16(cv_raw_s));
  // Results that land after the tracker has left LOCKED are dropped.
  assign update_s = log_valid_s && (state_r == LOCKED);

`ifdef PITCH_TO_CV_SMOOTH_EN
  logic                       fresh_r;
  logic signed [CV_ACC_W-1:0] step_s;

  assign step_s = (CV_ACC_W'(cv_new_s) - CV_ACC_W'(sample_out0)) >>> 2'd2;

  // CV output: first result after a lock from IDLE loads, later ones move a quarter of the way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_out0 <= W'(0);
      fresh_r     <= 1'b1;
    end else if (update_s) begin
      sample_out0 <= fresh_r ? cv_new_s : W'(CV_ACC_W'(sample_out0) + step_s);
      fresh_r     <= 1'b0;
    end else begin
      fresh_r     <= (state_r == IDLE) ? 1'b1 : fresh_r;
    end
  end
`else
  // CV output: load each new result directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_out0 <= W'(0);
    end else if (update_s) begin
      sample_out0 <= cv_new_s;
    end else begin
      sample_out0 <= sample_out0;
    end
  end
`endif

  assign sample_out3 = W'(0);

endmodule

// File: tb/tb_pitch_to_cv.sv
// Self-checking bench for pitch_to_cv against a per-strobe behavioural model.
module tb_pitch_to_cv;
  import pitch_to_cv_pkg::*;

  localparam int HYST   = 256;
  localparam int MIN_P  = 16;
  localparam int MAX_P  = 4096;
  localparam int CV_OFF = 46078;
  localparam int GATE   = 20000;
`ifdef PITCH_TO_CV_SMOOTH_EN
  localparam int CV_TOL = 28;
`else
  localparam int CV_TOL = 24;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               sample_strobe;
  logic signed [15:0] sample_in0, sample_in1, sample_in2, sample_in3;
  logic signed [15:0] sample_out0, sample_out1, sample_out2, sample_out3;
  logic [7:0]         jack;

  int n_checks = 0;
  int n_pass   = 0;
  bit gap_en   = 1'b0;

  int     m_level;
  int     m_count;
  int     m_out0;
  bit     m_fresh;
  state_e m_state;

  pitch_to_cv dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_strobe (sample_strobe),
    .sample_in0    (sample_in0),
    .sample_in1    (sample_in1),
    .sample_in2    (sample_in2),
    .sample_in3    (sample_in3),
    .sample_out0   (sample_out0),
    .sample_out1   (sample_out1),
    .sample_out2   (sample_out2),
    .sample_out3   (sample_out3),
    .jack          (jack)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp, input int tol);
    n_checks++;
    if (got >= exp - tol && got <= exp + tol) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ideal CV for a period: offset minus 4000 * log2(period), clamped.
  function automatic int ref_cv(input int p);
    real c;
    int  r;
    c = real'(CV_OFF) - 4000.0 * $ln(real'(p)) / $ln(2.0);
    r = int'(c);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic model_reset();
    m_level = 0;
    m_count = 0;
    m_out0  = 0;
    m_fresh = 1'b1;
    m_state = IDLE;
  endtask

  // One strobe of the tracker: m_count is strobes since the last rising edge, this one included.
  task automatic model_step(input int s);
    int nl;
    int p;
    int tgt;
    nl = (s > HYST) ? 1 : ((s < -HYST) ? 0 : m_level);
    m_count = m_count + 1;
    if (nl == 1 && m_level == 0) begin
      p = m_count;
      m_count = 0;
      if (m_state == IDLE) begin
        m_state = MEASURE;
      end else if (p >= MIN_P && p <= MAX_P) begin
        m_state = LOCKED;
        tgt = ref_cv(p);
`ifdef PITCH_TO_CV_SMOOTH_EN
        m_out0 = m_fresh ? tgt : m_out0 + ((tgt - m_out0) >>> 2);
`else
        m_out0 = tgt;
`endif
        m_fresh = 1'b0;
      end else begin
        m_state = MEASURE;
      end
    end else if (m_state != IDLE && m_count >= MAX_P) begin
      m_state = IDLE;
      m_fresh = 1'b1;
    end
    m_level = nl;
  endtask

  task automatic strobe(input int s);
    sample_in0    = 16'(s);
    sample_strobe = 1'b1;
    model_step(s);
    tick();
    sample_strobe = 1'b0;
    check_val("gate", int'(sample_out1), (m_state == LOCKED) ? GATE : 0, 0);
    check_val("square", int'(sample_out2), (m_level == 1) ? GATE : -GATE, 0);
    if (gap_en && $urandom_range(0, 3) == 0) tick();
  endtask

  task automatic wave_from(input int period, input int amp, input int start);
    for (int i = start; i < period; i++) begin
      strobe((i < (period + 1) / 2) ? amp : -amp);
    end
  endtask

  task automatic wave(input int period, input int ncyc, input int amp);
    for (int c = 0; c < ncyc; c++) begin
      wave_from(period, amp, 0);
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    sample_strobe = 1'b0;
    sample_in0    = 16'sd0;
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int per;
    int amp;
    rst_n         = 1'b0;
    sample_strobe = 1'b0;
    sample_in0    = 16'sd0;
    sample_in1    = 16'sd0;
    sample_in2    = 16'sd0;
    sample_in3    = 16'sd0;
    jack          = 8'd0;

    do_reset();
    check_val("rst_out0", int'(sample_out0), 0, 0);
    check_val("rst_out1", int'(sample_out1), 0, 0);
    check_val("rst_out2", int'(sample_out2), -GATE, 0);
    check_val("rst_out3", int'(sample_out3), 0, 0);
    check_val("rst_state", int'(dut.state_r), int'(IDLE), 0);

    // Noise inside the hysteresis band never produces an edge.
    for (int i = 0; i < 10000; i++) begin
      strobe(int'($urandom_range(0, 200)) - 100);
    end
    check_val("hyst_out0", int'(sample_out0), 0, 0);
    check_val("hyst_out1", int'(sample_out1), 0, 0);
    check_val("hyst_out2", int'(sample_out2), -GATE, 0);
    check_val("hyst_out3", int'(sample_out3), 0, 0);
    check_val("hyst_state", int'(dut.state_r), int'(IDLE), 0);

    // Lock at 367 and check the capture-to-output latency.
    wave(367, 1, 8000);
    strobe(8000);
    tick();
    tick();
    check_val("lat_e2", int'(sample_out0), 0, 0);
    tick();
    check_val("lat_e3", int'(sample_out0), 12000, 24);
    check_val("lat_model", int'(sample_out0), m_out0, CV_TOL);
    check_val("lock_out1", int'(sample_out1), GATE, 0);
    wave_from(367, 8000, 1);

    // One octave down.
    wave(734, 1, 8000);
    strobe(8000);
    tick();
    tick();
    tick();
`ifdef PITCH_TO_CV_SMOOTH_EN
    check_val("smooth_first", int'(sample_out0), 11000, 24);
`else
    check_val("oct_down", int'(sample_out0), 8000, 24);
`endif
    check_val("oct_model", int'(sample_out0), m_out0, CV_TOL);
    wave_from(734, 8000, 1);
    wave(734, 2, 8000);
    check_val("oct_settle", int'(sample_out0), m_out0, CV_TOL);

    // Relock at 367, then silence until the timeout.
    wave(367, 2, 8000);
    for (int j = 1; j <= 3735; j++) begin
      strobe(0);
      if (j == 3729) check_val("pre_timeout_out1", int'(sample_out1), GATE, 0);
      if (j == 3730) check_val("timeout_out1", int'(sample_out1), 0, 0);
    end
`ifndef PITCH_TO_CV_SMOOTH_EN
    check_val("timeout_hold", int'(sample_out0), 12000, 24);
`endif
    check_val("timeout_model", int'(sample_out0), m_out0, CV_TOL);
    check_val("timeout_state", int'(dut.state_r), int'(IDLE), 0);

    // Too-short periods are discarded.
    wave(8, 20, 8000);
    check_val("short_state", int'(dut.state_r), int'(MEASURE), 0);
    check_val("short_out1", int'(sample_out1), 0, 0);
    check_val("short_hold", int'(sample_out0), m_out0, CV_TOL);

    // Reset with a capture in flight must not update the output afterwards.
    do_reset();
    wave(400, 2, 8000);
    strobe(8000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) tick();
    check_val("flush_out0", int'(sample_out0), 0, 0);
    check_val("flush_out1", int'(sample_out1), 0, 0);
    check_val("flush_state", int'(dut.state_r), int'(IDLE), 0);

    // Random periods and amplitudes with irregular strobe spacing.
    gap_en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      per = int'($urandom_range(6, 900));
      amp = int'($urandom_range(300, 30000));
      wave(per, 3, amp);
      tick();
      tick();
      tick();
      tick();
      check_val("rand_cv", int'(sample_out0), m_out0, CV_TOL);
      check_val("rand_state", int'(dut.state_r), int'(m_state), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
